// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Multi-port register file with two write ports (ALU and load
//               writeback) and NRD combinational read ports. A busy
//               scoreboard is set on load issue and cleared by load
//               writeback. Register 0 is hardwired to zero.
//               Optional macro REGFILE_MP_BYPASS_EN compiles in
//               write-to-read forwarding on the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wren0,
  input  logic [ADDR_W-1:0]        wr0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     wren1,
  input  logic [ADDR_W-1:0]        wr1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [NRD*ADDR_W-1:0]    rr,
  output logic [NRD*DATA_W-1:0]    rd,
  output logic [NRD-1:0]           rbusy,
  output logic                     stall,
  output logic [DATA_W-1:0]        v0
);

  localparam int c_DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]  r_regs [c_DEPTH];
  logic [c_DEPTH-1:0] r_busy;

  // Register storage: port 1 wins over port 0 on the same address; entry 0
  // is only ever cleared, so it stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < c_DEPTH; i++) begin
        if (wren1 && (wr1 == ADDR_W'(i))) begin
          r_regs[i] <= wd1;
        end else if (wren0 && (wr0 == ADDR_W'(i))) begin
          r_regs[i] <= wd0;
        end
      end
    end
  end

  // Busy scoreboard: a new issue beats a same-edge load writeback; bit 0
  // never sets.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      for (int i = 1; i < c_DEPTH; i++) begin
        if (iss_en && (iss_addr == ADDR_W'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (wren1 && (wr1 == ADDR_W'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic [DATA_W-1:0] w_data;
      logic              w_busy;

      assign w_addr = rr[k*ADDR_W +: ADDR_W];

      // Per-port read: stored value, optionally overridden by same-cycle
      // write data (never while reset is held).
      always_comb begin
        w_data = '0;
        w_busy = 1'b0;
        if (w_addr != '0) begin
          w_data = r_regs[w_addr];
          w_busy = r_busy[w_addr];
`ifdef REGFILE_MP_BYPASS_EN
          if (rst && wren1 && (wr1 == w_addr)) begin
            w_data = wd1;
            w_busy = 1'b0;
          end else if (rst && wren0 && (wr0 == w_addr)) begin
            w_data = wd0;
          end
`endif
        end
      end

      assign rd[k*DATA_W +: DATA_W] = w_data;
      assign rbusy[k]               = w_busy;
    end
  endgenerate

  assign stall = |rbusy;
  assign v0    = r_regs[2];

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Directed self-checking bench for regfile_mp (NRD=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;
`ifdef REGFILE_MP_BYPASS_EN
  localparam bit c_BYP = 1'b1;
`else
  localparam bit c_BYP = 1'b0;
`endif

  logic                  clk;
  logic                  rst;
  logic                  wren0, wren1, iss_en;
  logic [ADDR_W-1:0]     wr0, wr1, iss_addr;
  logic [DATA_W-1:0]     wd0, wd1;
  logic [NRD*ADDR_W-1:0] rr;
  logic [NRD*DATA_W-1:0] rd;
  logic [NRD-1:0]        rbusy;
  logic                  stall;
  logic [DATA_W-1:0]     v0;

  int total = 0;
  int bad   = 0;

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) dut (
    .clk(clk), .rst(rst),
    .wren0(wren0), .wr0(wr0), .wd0(wd0),
    .wren1(wren1), .wr1(wr1), .wd1(wd1),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .rr(rr), .rd(rd), .rbusy(rbusy), .stall(stall), .v0(v0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wren0 = 0; wr0 = '0; wd0 = '0;
    wren1 = 0; wr1 = '0; wd1 = '0;
    iss_en = 0; iss_addr = '0;
  endtask

  task automatic set_rr(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    rr = {a1, a0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    set_rr(5, 9);
    #2;
    check("rst_rd0",   rd[31:0], 0);
    check("rst_rd1",   rd[63:32], 0);
    check("rst_rbusy", rbusy, 0);
    check("rst_stall", stall, 0);
    check("rst_v0",    v0, 0);
    @(negedge clk) rst = 1'b1;
    step();

    // Load r5, r2 and issue r9, then reset mid-cycle
    wren0 = 1; wr0 = 5; wd0 = 32'hDEADBEEF;
    wren1 = 1; wr1 = 2; wd1 = 32'hCAFE0002;
    iss_en = 1; iss_addr = 9;
    step(); idle(); set_rr(5, 9); #1;
    check("pre_rd0",   rd[31:0], 32'hDEADBEEF);
    check("pre_rbusy", rbusy, 2'b10);
    check("pre_stall", stall, 1);
    check("pre_v0",    v0, 32'hCAFE0002);
    #1 rst = 1'b0; #1;
    check("arst_rd0",   rd[31:0], 0);
    check("arst_v0",    v0, 0);
    check("arst_stall", stall, 0);
    // Inputs ignored while reset held
    wren0 = 1; wr0 = 5; wd0 = 32'h12345678; iss_en = 1; iss_addr = 5;
    set_rr(5, 5);
    #1 check("inrst_rd0", rd[31:0], 0);
    step();
    check("inrst_rd0b",  rd[31:0], 0);
    check("inrst_rbusy", rbusy, 0);
    idle(); #1 rst = 1'b1;
    step();
    check("post_rd0",   rd[31:0], 0);
    check("post_rbusy", rbusy, 0);

    // Zero register
    wren0 = 1; wr0 = 0; wd0 = 32'hFFFFFFFF; iss_en = 1; iss_addr = 0;
    set_rr(0, 0); #1;
    check("zero_same", rd[31:0], 0);
    step(); idle(); #1;
    check("zero_rd0",   rd[31:0], 0);
    check("zero_rd1",   rd[63:32], 0);
    check("zero_rbusy", rbusy, 0);

    // Write conflict: port 1 wins
    wren0 = 1; wr0 = 7; wd0 = 32'h11;
    wren1 = 1; wr1 = 7; wd1 = 32'h22;
    step(); idle(); set_rr(7, 0); #1;
    check("conf_rd0", rd[31:0], 32'h22);

    // Scoreboard set/clear
    iss_en = 1; iss_addr = 9;
    step(); idle(); set_rr(9, 0); #1;
    check("sb_busy", rbusy, 2'b01);
    check("sb_stall", stall, 1);
    wren1 = 1; wr1 = 9; wd1 = 32'h55; #1;
    check("sb_same_busy", rbusy, c_BYP ? 2'b00 : 2'b01);
    check("sb_same_rd0",  rd[31:0], c_BYP ? 32'h55 : 32'h0);
    step(); idle(); #1;
    check("sb_clr_busy",  rbusy, 0);
    check("sb_clr_stall", stall, 0);
    check("sb_clr_rd0",   rd[31:0], 32'h55);

    // Set/clear collision: issue wins, data still stored
    iss_en = 1; iss_addr = 4;
    step();
    wren1 = 1; wr1 = 4; wd1 = 32'h99;
    step(); idle(); set_rr(0, 4); #1;
    check("col_rd1",   rd[63:32], 32'h99);
    check("col_busy",  rbusy, 2'b10);
    check("col_stall", stall, 1);
    wren1 = 1; wr1 = 4; wd1 = 32'h100;
    step(); idle(); #1;
    check("col_clr", rbusy, 0);

    // Port 0 write leaves busy alone
    iss_en = 1; iss_addr = 6;
    step(); idle();
    wren0 = 1; wr0 = 6; wd0 = 32'h77;
    step(); idle(); set_rr(6, 0); #1;
    check("p0_rd0",  rd[31:0], 32'h77);
    check("p0_busy", rbusy, 2'b01);

    // Bypass on port 0, then priority wd1 over wd0
    wren1 = 1; wr1 = 3; wd1 = 32'h3333;
    step(); idle();
    wren0 = 1; wr0 = 3; wd0 = 32'hABCD; set_rr(3, 3); #1;
    check("byp0_rd0",  rd[31:0], c_BYP ? 32'hABCD : 32'h3333);
    wren1 = 1; wr1 = 3; wd1 = 32'hEEEE; #1;
    check("byp1_rd1",  rd[63:32], c_BYP ? 32'hEEEE : 32'h3333);
    wren1 = 0; #1;
    step(); idle(); #1;
    check("byp_after", rd[31:0], 32'hABCD);

    // v0 never bypassed
    wren0 = 1; wr0 = 2; wd0 = 32'h2222; #1;
    check("v0_same", v0, 0);
    step(); idle(); #1;
    check("v0_after", v0, 32'h2222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
